// File: rtl/uart_program_loader.sv
// Receives a framed program on the UART byte stream, packs big-endian 32-bit words
// into instruction memory and releases the core only after a good checksum.
module uart_program_loader #(
   parameter int          ADDR_W      = 8,
   parameter int          BASE_ADDR   = 0,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter int          TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_error
);

   // state  | meaning
   // IDLE   | no frame seen since reset
   // CNT_HI | waiting for word count high byte
   // CNT_LO | waiting for word count low byte
   // DATA   | collecting instruction bytes, 4 per word
   // CHECK  | waiting for the XOR checksum byte
   // DONE   | frame loaded, core released
   // ERROR  | frame aborted, core held
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] CNT_HI = 3'd1;
   localparam logic [2:0] CNT_LO = 3'd2;
   localparam logic [2:0] DATA   = 3'd3;
   localparam logic [2:0] CHECK  = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;
   localparam logic [2:0] ERROR  = 3'd6;

   localparam int          TMR_W     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [31:0] MAX_WORDS = 32'(2**ADDR_W - BASE_ADDR);

   logic [2:0]       state;
   logic [7:0]       count_hi;
   logic [15:0]      words_left;
   logic [1:0]       byte_idx;
   logic [7:0]       checksum;
   logic [23:0]      shift;
   logic [TMR_W-1:0] timer;
   logic             in_frame;

   assign in_frame = (state == CNT_HI) || (state == CNT_LO) ||
                     (state == DATA)   || (state == CHECK);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         imem_we    <= 1'b0;
         imem_addr  <= ADDR_W'(BASE_ADDR);
         imem_wdata <= 32'd0;
         cpu_hold   <= 1'b1;
         load_done  <= 1'b0;
         load_error <= 1'b0;
         count_hi   <= 8'd0;
         words_left <= 16'd0;
         byte_idx   <= 2'd0;
         checksum   <= 8'd0;
         shift      <= 24'd0;
         timer      <= '0;
      end else begin
         imem_we <= 1'b0;
         // Address advances the cycle after each write strobe.
         if (imem_we)
            imem_addr <= imem_addr + ADDR_W'(1);

         // A byte in the expiry cycle takes priority; only idle cycles count.
         if (in_frame && !rx_valid) begin
            if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
               state      <= ERROR;
               load_error <= 1'b1;
               timer      <= '0;
            end else begin
               timer <= timer + TMR_W'(1);
            end
         end

         case (state)
            IDLE, DONE, ERROR: begin
               if (rx_valid && rx_data == SYNC_BYTE) begin
                  state      <= CNT_HI;
                  cpu_hold   <= 1'b1;
                  load_done  <= 1'b0;
                  load_error <= 1'b0;
                  checksum   <= 8'd0;
                  imem_addr  <= ADDR_W'(BASE_ADDR);
                  byte_idx   <= 2'd0;
                  timer      <= '0;
               end
            end
            CNT_HI: begin
               if (rx_valid) begin
                  count_hi <= rx_data;
                  timer    <= '0;
                  state    <= CNT_LO;
               end
            end
            CNT_LO: begin
               if (rx_valid) begin
                  timer      <= '0;
                  words_left <= {count_hi, rx_data};
                  if (32'({count_hi, rx_data}) > MAX_WORDS) begin
                     state      <= ERROR;
                     load_error <= 1'b1;
                  end else if ({count_hi, rx_data} == 16'd0) begin
                     state <= CHECK;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (rx_valid) begin
                  timer    <= '0;
                  checksum <= checksum ^ rx_data;
                  byte_idx <= byte_idx + 2'd1;
                  shift    <= {shift[15:0], rx_data};
                  if (byte_idx == 2'd3) begin
                     imem_wdata <= {shift, rx_data};
                     imem_we    <= 1'b1;
                     words_left <= words_left - 16'd1;
                     if (words_left == 16'd1)
                        state <= CHECK;
                  end
               end
            end
            CHECK: begin
               if (rx_valid) begin
                  timer <= '0;
                  if (rx_data == checksum) begin
                     state     <= DONE;
                     cpu_hold  <= 1'b0;
                     load_done <= 1'b1;
                  end else begin
                     state      <= ERROR;
                     load_error <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: framed loads, checksum failure, empty
// frame, oversize count, inter-byte timeout and mid-frame reset.
module tb_uart_program_loader;

   localparam int TO = 40;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_error;

   int          n_chk  = 0;
   int          n_fail = 0;
   int          wr_count = 0;
   logic [7:0]  wr_addr [64];
   logic [31:0] wr_data [64];
   int          base;

   uart_program_loader #(
      .ADDR_W(8), .BASE_ADDR(0), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we === 1'b1 && wr_count < 64) begin
         wr_addr[wr_count] = imem_addr;
         wr_data[wr_count] = imem_wdata;
         wr_count++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame1(input logic [7:0] cs);
      send(8'hA5); send(8'h00); send(8'h02);
      send(8'h20); send(8'h08); send(8'h00); send(8'h05);
      chk("we_latency", {31'd0, imem_we}, 32'd1);
      chk("we_addr0", {24'd0, imem_addr}, 32'd0);
      chk("we_data0", imem_wdata, 32'h2008_0005);
      send(8'h00); send(8'h00); send(8'h00); send(8'h0C);
      send(cs);
      idle(3);
   endtask

   task automatic chk_frame1_writes(input int b);
      chk("f1_wr_count", 32'(wr_count - b), 32'd2);
      chk("f1_addr0", {24'd0, wr_addr[b]}, 32'd0);
      chk("f1_data0", wr_data[b], 32'h2008_0005);
      chk("f1_addr1", {24'd0, wr_addr[b+1]}, 32'd1);
      chk("f1_data1", wr_data[b+1], 32'h0000_000C);
   endtask

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      idle(2);
      chk("rst_we", {31'd0, imem_we}, 32'd0);
      chk("rst_addr", {24'd0, imem_addr}, 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
      chk("rst_done", {31'd0, load_done}, 32'd0);
      chk("rst_err", {31'd0, load_error}, 32'd0);
      reset = 1'b0;
      idle(2);

      // Good frame: checksum is the XOR of the eight data bytes = 0x21.
      base = wr_count;
      send_frame1(8'h21);
      chk_frame1_writes(base);
      chk("f1_done", {31'd0, load_done}, 32'd1);
      chk("f1_hold", {31'd0, cpu_hold}, 32'd0);
      chk("f1_err", {31'd0, load_error}, 32'd0);
      chk("f1_addr_after", {24'd0, imem_addr}, 32'd2);

      // Bad checksum: words still land, then error with core held.
      base = wr_count;
      send_frame1(8'h00);
      chk_frame1_writes(base);
      chk("bad_cs_err", {31'd0, load_error}, 32'd1);
      chk("bad_cs_hold", {31'd0, cpu_hold}, 32'd1);
      chk("bad_cs_done", {31'd0, load_done}, 32'd0);

      // Empty frame.
      base = wr_count;
      send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
      idle(3);
      chk("n0_writes", 32'(wr_count - base), 32'd0);
      chk("n0_done", {31'd0, load_done}, 32'd1);
      chk("n0_hold", {31'd0, cpu_hold}, 32'd0);

      // Count 257 exceeds 256-word memory.
      base = wr_count;
      send(8'hA5); send(8'h01);
      chk("n257_pre_err", {31'd0, load_error}, 32'd0);
      send(8'h01);
      chk("n257_err", {31'd0, load_error}, 32'd1);
      chk("n257_hold", {31'd0, cpu_hold}, 32'd1);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      idle(3);
      chk("n257_writes", 32'(wr_count - base), 32'd0);

      // Timeout exactly TO idle cycles after the last byte.
      base = wr_count;
      send(8'hA5); send(8'h00); send(8'h01); send(8'h20); send(8'h08);
      idle(TO - 1);
      chk("to_not_yet", {31'd0, load_error}, 32'd0);
      idle(1);
      chk("to_err", {31'd0, load_error}, 32'd1);
      chk("to_hold", {31'd0, cpu_hold}, 32'd1);
      send(8'h41);
      chk("ignored_err", {31'd0, load_error}, 32'd1);
      send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
      idle(3);
      chk("after_to_done", {31'd0, load_done}, 32'd1);
      chk("after_to_err", {31'd0, load_error}, 32'd0);
      chk("to_writes", 32'(wr_count - base), 32'd0);

      // Reset after third data byte.
      base = wr_count;
      send(8'hA5); send(8'h00); send(8'h01); send(8'hDE); send(8'hAD); send(8'hBE);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_we", {31'd0, imem_we}, 32'd0);
      chk("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
      chk("mid_rst_done", {31'd0, load_done}, 32'd0);
      chk("mid_rst_wdata", imem_wdata, 32'd0);
      reset = 1'b0;
      send(8'hEF);
      idle(3);
      chk("mid_rst_writes", 32'(wr_count - base), 32'd0);
      chk("mid_rst_err", {31'd0, load_error}, 32'd0);

      base = wr_count;
      send_frame1(8'h21);
      chk_frame1_writes(base);
      chk("reload_done", {31'd0, load_done}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
